// File: rtl/tone_detector.sv
// Square-wave tone detector: measures the half-period of a synchronised audio line
// and locks once LOCK_COUNT consecutive half-periods land inside the target band.
module tone_detector #(
  parameter int CNT_W       = 18,
  parameter int TARGET_HALF = 113637,
  parameter int TOLERANCE   = 1136,
  parameter int LOCK_COUNT  = 8,
  parameter int TIMEOUT     = 227274
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             audio_in,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             tone_detected,
  output logic             timeout_pulse
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] BAND_LO = CNT_W'(TARGET_HALF - TOLERANCE);
  localparam logic [CNT_W-1:0] BAND_HI = CNT_W'(TARGET_HALF + TOLERANCE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [MW-1:0]    LOCK_M1 = MW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, hp_n, measured;
  logic [MW-1:0]    match, match_n;
  logic             pv_n, tone_n, to_n;
  logic             s1, s2, s3, edge_det, in_band;

  // Synchroniser runs free: neither rst nor enable touches it, so releasing
  // reset never manufactures a phantom edge from a cleared flop.
  always_ff @(posedge clk) begin
    s1 <= audio_in;
    s2 <= s1;
    s3 <= s2;
  end

  assign edge_det = s2 ^ s3;
  assign measured = cnt + CNT_W'(1);
  assign in_band  = (measured >= BAND_LO) && (measured <= BAND_HI);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    match_n = match;
    hp_n    = half_period;
    pv_n    = 1'b0;
    tone_n  = tone_detected;
    to_n    = 1'b0;
    case (state)
      IDLE: begin
        if (edge_det) begin
          state_n = MEASURE;
          cnt_n   = '0;
          match_n = '0;
        end
      end
      default: begin
        if (edge_det) begin
          // An edge on the last count still wins over the timeout.
          cnt_n = '0;
          hp_n  = measured;
          pv_n  = 1'b1;
          if (in_band) begin
            if (state == MEASURE) begin
              match_n = match + MW'(1);
              if (match == LOCK_M1) begin
                state_n = LOCKED;
                tone_n  = 1'b1;
              end
            end
          end else begin
            state_n = MEASURE;
            match_n = '0;
            tone_n  = 1'b0;
          end
        end else if (cnt == CNT_MAX) begin
          state_n = IDLE;
          cnt_n   = '0;
          match_n = '0;
          tone_n  = 1'b0;
          to_n    = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state         <= IDLE;
      cnt           <= '0;
      match         <= '0;
      half_period   <= '0;
      period_valid  <= 1'b0;
      tone_detected <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      match         <= match_n;
      half_period   <= hp_n;
      period_valid  <= pv_n;
      tone_detected <= tone_n;
      timeout_pulse <= to_n;
    end
  end

endmodule

// File: tb/tb_tone_detector.sv
// Scoreboard bench for tone_detector with scaled-down timing parameters
// (target 100, band 95..105, lock 8, timeout 200).
module tb_tone_detector;

  localparam int CNT_W = 10;
  localparam int TGT   = 100;
  localparam int TOL   = 5;
  localparam int LOCK  = 8;
  localparam int TMO   = 200;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b1;
  logic             audio_in = 1'b0;
  logic [CNT_W-1:0] half_period;
  logic             period_valid, tone_detected, timeout_pulse;

  tone_detector #(.CNT_W(CNT_W), .TARGET_HALF(TGT), .TOLERANCE(TOL),
                  .LOCK_COUNT(LOCK), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .audio_in(audio_in),
    .half_period(half_period), .period_valid(period_valid),
    .tone_detected(tone_detected), .timeout_pulse(timeout_pulse));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_to;
    int hp;
    bit tone;
    int at;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string name, int got, int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
  endfunction

  // Monitor: every output event is matched against the head of the queue.
  always @(negedge clk) begin
    if (period_valid || timeout_pulse) begin
      if (q.size() == 0) begin
        chk("unexpected_event", {30'd0, period_valid, timeout_pulse}, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk(e.is_to ? "timeout_pulse" : "period_valid", e.is_to ? timeout_pulse : period_valid, 1);
        chk("event_cycle", cyc, e.at);
        chk("tone_detected", tone_detected, e.tone);
        if (!e.is_to) chk("half_period", half_period, e.hp);
      end
    end
  end

  // Reference: 0 idle, 1 measuring, 2 locked.
  int m_state = 0, m_match = 0, last_t = 0;

  task automatic tog(input int gap);
    int sp;
    repeat (gap) @(posedge clk);
    #1 audio_in = ~audio_in;
    sp = cyc - last_t;
    last_t = cyc;
    if (m_state == 0) begin
      m_state = 1;
      m_match = 0;
    end else begin
      bit inb;
      inb = (sp >= TGT - TOL) && (sp <= TGT + TOL);
      if (!inb) begin
        m_state = 1;
        m_match = 0;
      end else if (m_state == 1) begin
        m_match++;
        if (m_match == LOCK) m_state = 2;
      end
      q.push_back('{is_to: 1'b0, hp: sp, tone: (m_state == 2), at: cyc + 3});
    end
  endtask

  task automatic tog_n(input int n, input int gap);
    for (int i = 0; i < n; i++) tog(gap);
  endtask

  task automatic hold_timeout();
    if (m_state != 0)
      q.push_back('{is_to: 1'b1, hp: 0, tone: 1'b0, at: last_t + 3 + TMO});
    repeat (TMO + 10) @(posedge clk);
    m_state = 0;
    m_match = 0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_half_period"}, half_period, 0);
    chk({tag, "_period_valid"}, period_valid, 0);
    chk({tag, "_tone"}, tone_detected, 0);
    chk({tag, "_timeout"}, timeout_pulse, 0);
  endtask

  initial begin
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    // Target tone: arm + 9 half-periods, locks on the 9th edge.
    tog(20);
    tog_n(9, TGT);
    // Hold static while locked: timeout TMO cycles after last cnt reset, tone drops.
    hold_timeout();

    // Off-target tone never locks; timeout from MEASURE still pulses.
    tog(10);
    tog_n(20, 80);
    hold_timeout();

    // Inclusive band edges, an out-of-band 106 breaks the run of 7.
    tog(10);
    for (int i = 0; i < 7; i++) tog((i % 2) ? TGT + TOL : TGT - TOL);
    tog(TGT + TOL + 1);
    for (int i = 0; i < 8; i++) tog((i % 2) ? TGT - TOL : TGT + TOL);
    tog(TGT - TOL - 1);
    // Edge on the very last count beats the timeout and is published.
    tog(TMO);
    hold_timeout();

    // Synchronous reset mid-lock; first edge afterwards only re-arms.
    tog(10);
    tog_n(8, TGT);
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_cleared("rst_pulse");
    rst = 1'b0;
    m_state = 0;
    m_match = 0;
    tog(30);
    tog_n(8, TGT);

    // Short glitch period while locked drops lock; 8 more relock.
    tog(80);
    tog_n(8, TGT);

    // enable low behaves like reset.
    repeat (40) @(posedge clk);
    #1 enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_cleared("enable_low");
    enable = 1'b1;
    m_state = 0;
    m_match = 0;
    tog(30);
    tog(TGT);
    hold_timeout();

    repeat (20) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
